fpu_issue_ctrl: RTL



---
 rtl/fpu_issue_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/fpu_issue_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : fpu_issue_ctrl
// Function : FPU issue control with 3-slot writeback scoreboard and hazard stall
// Revision : 1.0
// =============================================================================
module fpu_issue_ctrl #(
    parameter int ADDR_W = 6,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [ADDR_W-1:0] in_fs,
    input  logic [ADDR_W-1:0] in_ft,
    input  logic              in_use_fs,
    input  logic              in_use_ft,
    input  logic [ADDR_W-1:0] in_fd,
    output logic [3:0]        fpu_ctrl,
    output logic [ADDR_W-1:0] fpu_dd,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_addr,
    output logic              busy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [3:1]        r_pend_v;
    logic [ADDR_W-1:0] r_pend_dd [1:3];
    logic [CNT_W-1:0]  r_stall_cnt;

    logic [1:0] w_lat;
    logic       w_nop;
    logic       w_port_ok;
    logic       w_raw;
    logic       w_waw;
    logic       w_fire;

    // Latency class 0 marks a NOP: always accepted, reserves no slot.
    function automatic logic [1:0] lat_of(input logic [3:0] op);
        case (op)
            4'd1, 4'd2:                      lat_of = 2'd2;
            4'd4, 4'd5:                      lat_of = 2'd3;
            4'd3, 4'd6, 4'd7, 4'd8, 4'd9,
            4'd10, 4'd11, 4'd12:             lat_of = 2'd1;
            default:                         lat_of = 2'd0;
        endcase
    endfunction

    assign w_lat = lat_of(in_op);
    assign w_nop = (w_lat == 2'd0);

    // The target slot must be free once the shift-down has happened.
    always_comb begin
        w_port_ok = 1'b1;
        case (w_lat)
            2'd1:    w_port_ok = ~r_pend_v[2];
            2'd2:    w_port_ok = ~r_pend_v[3];
            default: w_port_ok = 1'b1;
        endcase
    end

    always_comb begin
        w_raw = 1'b0;
        w_waw = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            if (r_pend_v[k]) begin
                if (in_use_fs && (in_fs != '0) && (r_pend_dd[k] == in_fs)) w_raw = 1'b1;
                if (in_use_ft && (in_ft != '0) && (r_pend_dd[k] == in_ft)) w_raw = 1'b1;
                if ((in_fd != '0) && (r_pend_dd[k] == in_fd))              w_waw = 1'b1;
            end
        end
    end

    assign in_ready = ~rst & (w_nop | (w_port_ok & ~w_raw & ~w_waw));
    assign w_fire   = in_valid & in_ready;
    assign fpu_ctrl = (w_fire && !w_nop) ? in_op : 4'd0;
    assign fpu_dd   = w_fire ? in_fd : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_v    <= '0;
            r_stall_cnt <= '0;
            for (int k = 1; k <= 3; k++) r_pend_dd[k] <= '0;
        end else begin
            r_pend_v     <= {1'b0, r_pend_v[3:2]};
            r_pend_dd[1] <= r_pend_dd[2];
            r_pend_dd[2] <= r_pend_dd[3];
            r_pend_dd[3] <= '0;
            if (w_fire) begin
                case (w_lat)
                    2'd1: begin r_pend_v[1] <= 1'b1; r_pend_dd[1] <= in_fd; end
                    2'd2: begin r_pend_v[2] <= 1'b1; r_pend_dd[2] <= in_fd; end
                    2'd3: begin r_pend_v[3] <= 1'b1; r_pend_dd[3] <= in_fd; end
                    default: ;
                endcase
            end
            if (in_valid && !in_ready && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
        end
    end

    assign wb_valid  = r_pend_v[1];
    assign wb_addr   = r_pend_dd[1];
    assign busy      = |r_pend_v;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire
